fwd_hazard_ctrl: RTL
====================

Name: fwd_hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core.
- Keeps shadow copies of the register-usage fields for EX, MEM and WB, and generates the 2-bit selects for the two EX-stage 3-to-1 operand muxes.
- Detects load-use hazards and inserts one bubble; squashes wrong-path instructions on a taken branch.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- CNT_W, 16, width of the stall and flush event counters (saturating).

Ports:
- clk_i  input  1  core clock; all state updates on the rising edge.
- rst_i  input  1  reset; asynchronous, active-low.
- id_valid_i  input  1  ID stage holds a real instruction.
- id_rs1_i  input  5  ID source register 1.
- id_rs2_i  input  5  ID source register 2.
- id_use_rs1_i  input  1  ID instruction reads rs1.
- id_use_rs2_i  input  1  ID instruction reads rs2.
- id_rd_i  input  5  ID destination register.
- id_regwrite_i  input  1  ID instruction writes rd.
- id_memread_i  input  1  ID instruction is a load.
- ex_branch_taken_i  input  1  branch/jump resolved taken in EX this cycle.
- fwd_a_o  output  2  EX operand-A mux select: 00 regfile, 01 MEM/WB data, 10 EX/MEM ALU result.
- fwd_b_o  output  2  EX operand-B mux select, same encoding as fwd_a_o.
- stall_o  output  1  hold PC and IF/ID this cycle.
- idex_bubble_o  output  1  load NOPs into ID/EX this cycle.
- ifid_flush_o  output  1  load NOP into IF/ID this cycle.
- stall_cnt_o  output  CNT_W  count of load-use stall cycles.
- flush_cnt_o  output  CNT_W  count of taken-branch flushes.

Behaviour:

Internal state:
- EX slot: ex_rs1, ex_rs2, ex_use1, ex_use2, ex_rd, ex_rw, ex_mr.
- MEM slot: mem_rd, mem_rw.
- WB slot: wb_rd, wb_rw.

Reset (rst_i low, asynchronous):
- All slot fields cleared to 0.
- Both counters cleared to 0.
- Outputs during reset: fwd_a_o = fwd_b_o = 00; stall_o, idex_bubble_o, ifid_flush_o = 0.
- Reset asserted mid-stall or mid-flush drops the event immediately; there is no residual bubble after release.

Forwarding (combinational from EX/MEM/WB slot registers only; zero added latency):
- fwd_a_o = 10 if ex_use1 && mem_rw && mem_rd != 0 && mem_rd == ex_rs1.
- Else fwd_a_o = 01 if ex_use1 && wb_rw && wb_rd != 0 && wb_rd == ex_rs1.
- Else fwd_a_o = 00.
- fwd_b_o follows the same rules using ex_use2 / ex_rs2.
- Selects 11 are never driven.
- The register file is write-before-read, so no WB-to-ID path exists in this block.

Load-use hazard:
- load_use = id_valid_i && ex_mr && ex_rd != 0 && ((id_use_rs1_i && id_rs1_i == ex_rd) || (id_use_rs2_i && id_rs2_i == ex_rd)).
- On load_use: stall_o = 1 and idex_bubble_o = 1.
- Exactly one stall cycle: next cycle the load is in MEM and ex_mr = 0, so the consumer then forwards via 01.

Taken branch (ex_branch_taken_i = 1):
- ifid_flush_o = 1 and idex_bubble_o = 1.
- stall_o is forced to 0; the flush has priority over load_use in the same cycle.

Stage advance (every rising edge, not in reset):
- WB slot <= MEM slot; MEM slot <= EX slot (mem_rw <= ex_rw).
- The EX slot advances unconditionally because the EX stage is never held.
- If idex_bubble_o = 1 or id_valid_i = 0: EX slot loads a bubble (rw = mr = use1 = use2 = 0, rd = 0).
- Otherwise the EX slot loads the id_* fields.

Counters:
- stall_cnt_o increments on each cycle with stall_o = 1.
- flush_cnt_o increments on each cycle with ex_branch_taken_i = 1.
- Both saturate at all-ones and never wrap.

Test Plan:
- Back-to-back dependency: add x1,x2,x3 then add x4,x1,x5 -> on the consumer's EX cycle fwd_a_o = 10, fwd_b_o = 00, stall_o = 0.
- Distance-2 and double-hazard: producer x1, one independent instruction, consumer x1 -> fwd_a_o = 01. If both MEM and WB write x1 -> fwd_a_o = 10 (MEM priority). Any sequence targeting x0 -> fwd selects stay 00.
- Load-use: lw x6,0(x2) then add x7,x6,x6 -> exactly one cycle with stall_o = 1 and idex_bubble_o = 1; next consumer EX cycle fwd_a_o = fwd_b_o = 01; stall_cnt_o = 1.
- Branch flush with a simultaneous load-use match -> ifid_flush_o = 1, idex_bubble_o = 1, stall_o = 0; flush_cnt_o +1, stall_cnt_o unchanged; squashed instructions never produce forwarding.
- Counter saturation with CNT_W = 4: 20 load-use events -> stall_cnt_o holds 4'hF.
- Reset asserted during a stall cycle -> all outputs 0 asynchronously (before the next edge); after release, a producer-consumer pair placed in EX/MEM at reset leaves fwd selects at 00.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select, load-use stall and branch-flush control for a 5-stage pipeline,
// with shadow EX/MEM/WB register-usage slots and saturating event counters.
module fwd_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             ex_branch_taken_i,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             stall_o,
    output logic             idex_bubble_o,
    output logic             ifid_flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [4:0] ex_rs1_q, ex_rs2_q, ex_rd_q, mem_rd_q, wb_rd_q;
    logic       ex_use1_q, ex_use2_q, ex_rw_q, ex_mr_q, mem_rw_q, wb_rw_q;

    logic [4:0] ex_rs1_d, ex_rs2_d, ex_rd_d;
    logic       ex_use1_d, ex_use2_d, ex_rw_d, ex_mr_d;

    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             load_use;

    function automatic logic [1:0] fwd_sel(input logic rd_read, input logic [4:0] rs,
                                           input logic m_rw, input logic [4:0] m_rd,
                                           input logic w_rw, input logic [4:0] w_rd);
        logic [1:0] sel;
        sel = 2'b00;
        if (rd_read && w_rw && (w_rd != 5'd0) && (w_rd == rs)) sel = 2'b01;
        // MEM holds the younger write, so it overrides WB.
        if (rd_read && m_rw && (m_rd != 5'd0) && (m_rd == rs)) sel = 2'b10;
        return sel;
    endfunction

    assign fwd_a_o = fwd_sel(ex_use1_q, ex_rs1_q, mem_rw_q, mem_rd_q, wb_rw_q, wb_rd_q);
    assign fwd_b_o = fwd_sel(ex_use2_q, ex_rs2_q, mem_rw_q, mem_rd_q, wb_rw_q, wb_rd_q);

    assign load_use = id_valid_i && ex_mr_q && (ex_rd_q != 5'd0) &&
                      ((id_use_rs1_i && (id_rs1_i == ex_rd_q)) ||
                       (id_use_rs2_i && (id_rs2_i == ex_rd_q)));

    // Gated by reset so an in-flight event vanishes the moment reset asserts.
    assign stall_o       = rst_i && load_use && !ex_branch_taken_i;
    assign ifid_flush_o  = rst_i && ex_branch_taken_i;
    assign idex_bubble_o = rst_i && (load_use || ex_branch_taken_i);

    always_comb begin
        ex_rs1_d  = 5'd0;
        ex_rs2_d  = 5'd0;
        ex_rd_d   = 5'd0;
        ex_use1_d = 1'b0;
        ex_use2_d = 1'b0;
        ex_rw_d   = 1'b0;
        ex_mr_d   = 1'b0;
        if (id_valid_i && !idex_bubble_o) begin
            ex_rs1_d  = id_rs1_i;
            ex_rs2_d  = id_rs2_i;
            ex_rd_d   = id_rd_i;
            ex_use1_d = id_use_rs1_i;
            ex_use2_d = id_use_rs2_i;
            ex_rw_d   = id_regwrite_i;
            ex_mr_d   = id_memread_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_rs1_q  <= 5'd0;
            ex_rs2_q  <= 5'd0;
            ex_rd_q   <= 5'd0;
            ex_use1_q <= 1'b0;
            ex_use2_q <= 1'b0;
            ex_rw_q   <= 1'b0;
            ex_mr_q   <= 1'b0;
            mem_rd_q  <= 5'd0;
            mem_rw_q  <= 1'b0;
            wb_rd_q   <= 5'd0;
            wb_rw_q   <= 1'b0;
        end else begin
            ex_rs1_q  <= ex_rs1_d;
            ex_rs2_q  <= ex_rs2_d;
            ex_rd_q   <= ex_rd_d;
            ex_use1_q <= ex_use1_d;
            ex_use2_q <= ex_use2_d;
            ex_rw_q   <= ex_rw_d;
            ex_mr_q   <= ex_mr_d;
            mem_rd_q  <= ex_rd_q;
            mem_rw_q  <= ex_rw_q;
            wb_rd_q   <= mem_rd_q;
            wb_rw_q   <= mem_rw_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_o && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (ex_branch_taken_i && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
